// File: rtl/fp8_pkg.sv
`timescale 1ns/1ps
// Shared widths, FSM state type and field helpers for the 8-bit mini-float add/sub sequencer.
package fp8_pkg;

  localparam int unsigned EXP_W   = 3;
  localparam int unsigned FRACT_W = 4;
  localparam int unsigned GUARD_W = 2;
  localparam int unsigned MANT_W  = 1 + FRACT_W + GUARD_W;
  localparam int unsigned SUM_W   = MANT_W + 1;
  localparam int unsigned WORD_W  = 1 + EXP_W + FRACT_W;

  localparam logic [EXP_W+FRACT_W-1:0] SAT_MAX = 7'b111_1111;
  localparam logic [EXP_W-1:0]         EXP_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    DONE
  } state_t;

  function automatic logic get_sign(input logic [WORD_W-1:0] w);
    return w[WORD_W-1];
  endfunction

  function automatic logic [EXP_W-1:0] get_exp(input logic [WORD_W-1:0] w);
    return w[WORD_W-2 -: EXP_W];
  endfunction

  function automatic logic [FRACT_W-1:0] get_fract(input logic [WORD_W-1:0] w);
    return w[FRACT_W-1:0];
  endfunction

  function automatic logic [EXP_W+FRACT_W-1:0] get_mag(input logic [WORD_W-1:0] w);
    return w[WORD_W-2:0];
  endfunction

  function automatic logic [WORD_W-1:0] pack(input logic                s,
                                             input logic [EXP_W-1:0]   e,
                                             input logic [FRACT_W-1:0] f);
    return {s, e, f};
  endfunction

  // Hidden one above the fraction, guard bits cleared below it.
  function automatic logic [MANT_W-1:0] mant_of(input logic [FRACT_W-1:0] f);
    return {1'b1, f, {GUARD_W{1'b0}}};
  endfunction

endpackage

// File: rtl/fp8_mant_shreg.sv
`timescale 1ns/1ps
// Loadable mantissa register: load > shift right > shift left > hold.
// Ports: clk, rst_n, load_i/load_val_i, shr_i, shl_i, q_o.
module fp8_mant_shreg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         shr_i,
  input  logic         shl_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = load_val_i;
    end else if (shr_i) begin
      q_d = {1'b0, q_q[W-1:1]};
    end else if (shl_i) begin
      q_d = {q_q[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/fp8_addsub_seq.sv
`timescale 1ns/1ps
// Multi-cycle mini-float add/subtract: one-bit-per-cycle alignment and normalisation.
// Ports: in_valid/in_ready/op_a/op_b/op_sub in, out_valid/out_ready/result/flags out, busy.
module fp8_addsub_seq
  import fp8_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] op_a,
  input  logic [WORD_W-1:0] op_b,
  input  logic              op_sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] result,
  output logic              flag_zero,
  output logic              flag_ovf,
  output logic              flag_unf,
  output logic              busy
);

  state_t state_q, state_d;

  logic [MANT_W-1:0] big_q, big_d;
  logic [EXP_W-1:0]  cnt_q, cnt_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic              sign_a_q, sign_a_d;
  logic              eff_sub_q, eff_sub_d;
  logic              res_sign_q, res_sign_d;
  logic [WORD_W-1:0] result_q, result_d;
  logic              zero_q, zero_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic [WORD_W-1:0] b_eff, wa, wb;
  logic              swap;
  logic [SUM_W-1:0]  sum_calc;

  logic              sm_load, sm_shr;
  logic [MANT_W-1:0] sm_val, small_q;
  logic              sum_load, sum_shr, sum_shl;
  logic [SUM_W-1:0]  sum_q;

  assign b_eff    = {op_b[WORD_W-1] ^ op_sub, op_b[WORD_W-2:0]};
  assign swap     = get_mag(b_eff) > get_mag(op_a);
  assign wa       = swap ? b_eff : op_a;
  assign wb       = swap ? op_a : b_eff;
  assign sm_val   = mant_of(get_fract(wb));
  assign sum_calc = eff_sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                              : ({1'b0, big_q} + {1'b0, small_q});

  fp8_mant_shreg #(.W(MANT_W)) u_small (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (sm_load),
    .load_val_i(sm_val),
    .shr_i     (sm_shr),
    .shl_i     (1'b0),
    .q_o       (small_q)
  );

  fp8_mant_shreg #(.W(SUM_W)) u_sum (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (sum_load),
    .load_val_i(sum_calc),
    .shr_i     (sum_shr),
    .shl_i     (sum_shl),
    .q_o       (sum_q)
  );

  always_comb begin
    state_d    = state_q;
    big_d      = big_q;
    cnt_d      = cnt_q;
    exp_d      = exp_q;
    sign_a_d   = sign_a_q;
    eff_sub_d  = eff_sub_q;
    res_sign_d = res_sign_q;
    result_d   = result_q;
    zero_d     = zero_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    sm_load    = 1'b0;
    sm_shr     = 1'b0;
    sum_load   = 1'b0;
    sum_shr    = 1'b0;
    sum_shl    = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          big_d     = mant_of(get_fract(wa));
          sm_load   = 1'b1;
          cnt_d     = get_exp(wa) - get_exp(wb);
          exp_d     = get_exp(wa);
          sign_a_d  = get_sign(wa);
          eff_sub_d = get_sign(wa) ^ get_sign(wb);
          zero_d    = 1'b0;
          ovf_d     = 1'b0;
          unf_d     = 1'b0;
          state_d   = ALIGN;
        end
      end
      ALIGN: begin
        if (cnt_q != '0) begin
          sm_shr = 1'b1;
          cnt_d  = cnt_q - 1'b1;
        end else begin
          state_d = ADD;
        end
      end
      ADD: begin
        sum_load   = 1'b1;
        res_sign_d = (sum_calc == '0) ? 1'b0 : sign_a_q;
        state_d    = NORM;
      end
      NORM: begin
        if (sum_q == '0) begin
          result_d = '0;
          zero_d   = 1'b1;
          state_d  = DONE;
        end else if (sum_q[SUM_W-1]) begin
          if (exp_q == EXP_MAX) begin
            result_d = {res_sign_q, SAT_MAX};
            ovf_d    = 1'b1;
            state_d  = DONE;
          end else begin
            // Carry-out shift counts as one normalisation step; the
            // following NORM cycle sees sum[6] set and packs.
            sum_shr = 1'b1;
            exp_d   = exp_q + 1'b1;
          end
        end else if (sum_q[SUM_W-2]) begin
          result_d = pack(res_sign_q, exp_q, sum_q[SUM_W-3 -: FRACT_W]);
          state_d  = DONE;
        end else if (exp_q == '0) begin
          result_d = '0;
          unf_d    = 1'b1;
          state_d  = DONE;
        end else begin
          sum_shl = 1'b1;
          exp_d   = exp_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      big_q      <= '0;
      cnt_q      <= '0;
      exp_q      <= '0;
      sign_a_q   <= 1'b0;
      eff_sub_q  <= 1'b0;
      res_sign_q <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      big_q      <= big_d;
      cnt_q      <= cnt_d;
      exp_q      <= exp_d;
      sign_a_q   <= sign_a_d;
      eff_sub_q  <= eff_sub_d;
      res_sign_q <= res_sign_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;
  assign flag_zero = zero_q;
  assign flag_ovf  = ovf_q;
  assign flag_unf  = unf_q;

endmodule
